// File: rtl/li_credit_receiver.sv
// Credit-based receive buffer: a first-word-fall-through circular FIFO.
// It returns one credit pulse to the sender for every word the consumer takes.
module li_credit_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic signed [DATA_WIDTH-1:0]       i_data,
  input  logic                               i_valid,
  output logic                               o_li_feedback,
  output logic signed [DATA_WIDTH-1:0]       o_data,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          feedback_reg;
  logic          overflow_reg;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // Both inputs are qualified by reset so nothing is accepted or credited during reset.
  assign full = (count_reg == COUNT_FULL);
  assign pop  = reset & o_valid & i_ready;
  assign push = reset & i_valid & (~full | pop);
  assign drop = reset & i_valid & full & ~pop;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      feedback_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg    <= count_next;
      feedback_reg <= pop;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; occupancy alone marks entries as live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  assign o_valid       = (count_reg != '0);
  assign o_data        = mem[rd_ptr_reg];
  assign o_count       = count_reg;
  assign o_li_feedback = feedback_reg;
  assign o_overflow    = overflow_reg;

endmodule

// File: tb/tb_li_credit_receiver.sv
// Bench for li_credit_receiver: a vector table, hand-written corner sequences,
// and a random credit-respecting sender checked against a queue model.
module tb_li_credit_receiver;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic                  clock;
  logic                  reset;
  logic signed [DW-1:0]  i_data;
  logic                  i_valid;
  logic                  o_li_feedback;
  logic signed [DW-1:0]  o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [2:0]            o_count;
  logic                  o_overflow;

  int checks = 0;
  int errors = 0;

  li_credit_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_li_feedback(o_li_feedback),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_count(o_count),
    .o_overflow(o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  ec;
    logic        ef;
    logic        eo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_n, input logic v, input logic [15:0] d, input logic r,
                     input logic ev, input logic [15:0] ed, input logic [2:0] ec,
                     input logic ef, input logic eo);
    vec_t t;
    t = '{rst_n, v, d, r, ev, ed, ec, ef, eo};
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Applies one cycle of inputs and returns #1 after the capturing edge.
  task automatic step(input logic rst_n, input logic v, input logic [15:0] d, input logic r);
    reset   = rst_n;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [15:0] ed,
                            input logic [2:0] ec, input logic ef, input logic eo);
    check({tag, ".valid"}, 32'(o_valid), 32'(ev));
    if (ev) check({tag, ".data"}, 32'(16'(o_data)), 32'(ed));
    check({tag, ".count"}, 32'(o_count), 32'(ec));
    check({tag, ".fb"}, 32'(o_li_feedback), 32'(ef));
    check({tag, ".ovf"}, 32'(o_overflow), 32'(eo));
    $display("%s: valid=%0d data=%04h count=%0d fb=%0d ovf=%0d", tag, o_valid,
             16'(o_data), o_count, o_li_feedback, o_overflow);
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] d;
    logic        v;
    logic        r;
    logic        exp_pop;
    int          credits;
    int          popped;
    int          returned;
    int          fb_seen;

    reset = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;

    // rst_n v d r | valid data count fb ovf
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 1, 16'h0011, 0, 1, 16'h0011, 1, 0, 0); // one-cycle latency
    add(1, 1, 16'h0022, 1, 1, 16'h0022, 1, 1, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0); // ready ignored when empty
    add(1, 1, 16'h0001, 0, 1, 16'h0001, 1, 0, 0);
    add(1, 1, 16'h0002, 0, 1, 16'h0001, 2, 0, 0);
    add(1, 1, 16'h0003, 0, 1, 16'h0001, 3, 0, 0);
    add(1, 1, 16'h0004, 0, 1, 16'h0001, 4, 0, 0);
    add(1, 1, 16'h0005, 0, 1, 16'h0001, 4, 0, 1); // overflow, word dropped
    add(1, 0, 16'h0000, 0, 1, 16'h0001, 4, 0, 1); // head stable while stalled
    add(1, 0, 16'h0000, 1, 1, 16'h0002, 3, 1, 1);
    add(1, 0, 16'h0000, 1, 1, 16'h0003, 2, 1, 1);
    add(1, 0, 16'h0000, 1, 1, 16'h0004, 1, 1, 1);
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
    add(0, 1, 16'h00FF, 1, 0, 16'h0000, 0, 0, 0); // reset clears overflow
    add(1, 1, 16'h0010, 0, 1, 16'h0010, 1, 0, 0);
    add(1, 1, 16'h0020, 0, 1, 16'h0010, 2, 0, 0);
    add(1, 1, 16'h0030, 0, 1, 16'h0010, 3, 0, 0);
    add(1, 1, 16'h0040, 0, 1, 16'h0010, 4, 0, 0);
    add(1, 1, 16'h00AA, 1, 1, 16'h0020, 4, 1, 0); // full push with pop
    add(1, 0, 16'h0000, 1, 1, 16'h0030, 3, 1, 0);
    add(1, 0, 16'h0000, 1, 1, 16'h0040, 2, 1, 0);
    add(1, 0, 16'h0000, 1, 1, 16'h00AA, 1, 1, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst_n, vq[i].v, vq[i].d, vq[i].r);
      check_outs($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].ec, vq[i].ef, vq[i].eo);
    end

    // Ten streamed words with the consumer always ready, wrapping the pointers.
    fb_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 16'h0100 + 16'(k), 1);
      check_outs($sformatf("stream%0d", k), 1'b1, 16'h0100 + 16'(k), 3'd1, (k > 0), 1'b0);
      if (o_li_feedback) fb_seen++;
    end
    step(1, 0, 16'h0000, 1);
    check_outs("stream_drain", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);
    if (o_li_feedback) fb_seen++;
    step(1, 0, 16'h0000, 0);
    check_outs("stream_idle", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    check("stream_credits", 32'(fb_seen), 32'd10);

    // Reset with words buffered: nothing survives and nothing is credited.
    step(1, 1, 16'h0A01, 0);
    step(1, 1, 16'h0A02, 0);
    step(1, 1, 16'h0A03, 0);
    check_outs("pre_reset", 1'b1, 16'h0A01, 3'd3, 1'b0, 1'b0);
    step(0, 1, 16'h0BAD, 1);
    check_outs("mid_reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step(1, 0, 16'h0000, 1);
    check_outs("post_reset0", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step(1, 1, 16'h0077, 0);
    check_outs("post_reset1", 1'b1, 16'h0077, 3'd1, 1'b0, 1'b0);
    step(1, 0, 16'h0000, 1);
    check_outs("post_reset2", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);

    // Random traffic from a sender that only transmits while holding credits.
    step(0, 0, 16'h0000, 0);
    q.delete();
    credits = DEPTH;
    popped = 0;
    returned = 0;
    for (int n = 0; n < 500; n++) begin
      v = (credits > 0) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0) || (n >= 480);
      if (n >= 480) v = 1'b0;
      d = 16'($urandom);
      exp_pop = (q.size() > 0) && r;
      if (v) credits--;
      step(1, v, d, r);
      if (exp_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (v) q.push_back(d);
      checks++;
      if (o_valid !== (q.size() != 0) || o_count !== 3'(q.size()) ||
          o_li_feedback !== exp_pop || o_overflow !== 1'b0 ||
          (q.size() != 0 && 16'(o_data) !== q[0])) begin
        errors++;
        $display("FAIL rand%0d actual v=%0d d=%04h c=%0d fb=%0d ovf=%0d required v=%0d d=%04h c=%0d fb=%0d ovf=0",
                 n, o_valid, 16'(o_data), o_count, o_li_feedback, o_overflow,
                 (q.size() != 0), (q.size() != 0) ? q[0] : 16'h0, q.size(), exp_pop);
      end
      if (n % 50 == 0)
        $display("rand%0d: v=%0d r=%0d count=%0d fb=%0d credits=%0d", n, v, r, o_count,
                 o_li_feedback, credits);
      if (o_li_feedback) begin
        credits++;
        returned++;
      end
    end
    check("rand_returned_vs_popped", 32'(returned), 32'(popped));
    check("rand_final_credits", 32'(credits), 32'(DEPTH));
    check("rand_final_count", 32'(o_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/li_credit_receiver.md
LI_CREDIT_RECEIVER -- requirements
Module: li_credit_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning data input/output bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning buffer entries, equal to the credits the sender holds at reset; power of two, >= 2.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_data  input  signed [DATA_WIDTH-1:0]  data word from the interconnect.
REQ-006 SHALL have port i_valid  input  1  i_data is valid this cycle.
REQ-007 SHALL have port o_li_feedback  output  1  credit-return pulse to the interconnect; one pulse per freed entry.
REQ-008 SHALL have port o_data  output  signed [DATA_WIDTH-1:0]  head-of-buffer word to the consumer.
REQ-009 SHALL have port o_valid  output  1  o_data is valid.
REQ-010 SHALL have port i_ready  input  1  consumer accepts o_data this cycle.
REQ-011 SHALL have port o_count  output  [$clog2(FIFO_DEPTH+1)-1:0]  current occupancy.
REQ-012 SHALL have port o_overflow  output  1  sticky error flag: a word arrived with no free entry.

Function
REQ-013 SHALL implement a circular buffer of FIFO_DEPTH entries with write and read pointers of $clog2(FIFO_DEPTH) bits, each wrapping from FIFO_DEPTH-1 to 0.
REQ-014 SHALL define push = i_valid and (o_count < FIFO_DEPTH or pop), and pop = o_valid and i_ready.
REQ-015 SHALL, on push, write i_data at the write pointer and advance the write pointer by one.
REQ-016 SHALL, on pop, advance the read pointer by one.
REQ-017 SHALL update o_count as +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-018 SHALL drive o_valid as (o_count != 0) and o_data as the entry at the read pointer (first-word-fall-through); o_data is don't-care while o_valid = 0.
REQ-019 SHALL make a word pushed at edge t visible on o_data/o_valid at edge t+1 when the buffer was empty: one-cycle latency.
REQ-020 SHALL accept a push when the buffer is full and a pop occurs in the same cycle; occupancy stays FIFO_DEPTH.
REQ-021 SHALL, when i_valid = 1, the buffer is full and there is no pop, discard i_data, leave pointers and count unchanged, and set o_overflow = 1 until reset.
REQ-022 SHALL register o_li_feedback as the pop of the previous cycle: exactly one 1-cycle pulse per popped word, asserted the cycle after the pop.
REQ-023 SHALL produce back-to-back credit pulses when pops occur on consecutive cycles, with no merging or loss.
REQ-024 SHALL keep o_data stable while o_valid = 1 and i_ready = 0.
REQ-025 SHALL ignore i_ready while o_valid = 0: no pop, no credit.

Reset
REQ-026 SHALL, while reset = 0 at a clock edge, clear the pointers, o_count, o_overflow and o_li_feedback, so that o_valid = 0.
REQ-027 SHALL discard buffered words on reset mid-operation and return no credits for them; the sender re-initialises to FIFO_DEPTH credits.
REQ-028 SHALL ignore i_valid and i_ready during the reset cycles.
REQ-029 SHALL not reset buffer storage contents.

Verification
REQ-030 SHALL cover: DEPTH=4, push 0x0011, i_ready=0 -> next cycle o_valid=1, o_data=0x0011, o_count=1, o_li_feedback=0.
REQ-031 SHALL cover: push 0x0001..0x0004, i_ready=0, then i_valid with 0x0005 -> o_count stays 4, o_overflow=1, and pops then return 0x0001..0x0004 in order.
REQ-032 SHALL cover: buffer full, push 0x00AA with i_ready=1 in the same cycle -> head popped, o_count=4, 0x00AA is the last word out, o_li_feedback=1 the next cycle.
REQ-033 SHALL cover: 10 consecutive words with i_ready=1 throughout -> output order preserved across pointer wrap, 10 credit pulses each one cycle after its pop, o_count <= 1.
REQ-034 SHALL cover: 3 words buffered, reset=0 for one cycle -> o_valid=0, o_count=0, o_overflow=0, no credit pulses, and a new push after reset is output correctly.
REQ-035 SHALL cover: random i_valid/i_ready with a credit-respecting sender model (initial 4 credits) -> o_overflow stays 0, no data loss, and total credits returned equals words popped.
